pc_fetch_sequencer: RTL

- Sequences the program counter and the instruction-memory fetch for the single-issue core.
- Holds the architectural PC and issues one fetch request at a time to instruction memory. It hands the fetched word to decode over a valid/ready handshake.
- Applies branch/jump redirects from execute, supports halt/resume and counts issued instructions.
- Sits between the PC register path, instruction memory and decode.

---
 rtl/pc_fetch_sequencer_pkg.sv | 19 +
 rtl/pc_fetch_sequencer_if.sv | 45 ++++
 rtl/pc_fetch_sequencer_pc_next_sel.sv | 33 +++
 rtl/pc_fetch_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// pc_fetch_sequencer_pkg
//   Shared defaults and types for the fetch sequencer slice.
//   - DEF_* : default widths / increment / reset address
//   - state_t : sequencer state (FETCH / ISSUE / HALT); 2'd3 is unused
//     and decodes back to FETCH.
package pc_fetch_sequencer_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 32;
   localparam int unsigned DEF_INST_WIDTH = 32;
   localparam int unsigned DEF_PC_INCR    = 1;
   localparam int unsigned DEF_CNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_ISSUE = 2'd1,
      S_HALT  = 2'd2
   } state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if
//   Bundles the instruction-memory, decode, execute-redirect and status
//   signals of the fetch sequencer.
//   master : sequencer side (drives imem_req/addr, inst_*, halted, pc_out,
//            issue_count; samples imem_ack/rdata, inst_ready, redirect_*,
//            halt_req)
//   slave  : environment side (memory, decode, execute)
interface pc_fetch_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned INST_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
);
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_ack;
   logic [INST_WIDTH-1:0] imem_rdata;
   logic                  inst_valid;
   logic                  inst_ready;
   logic [INST_WIDTH-1:0] inst_out;
   logic [ADDR_WIDTH-1:0] inst_pc;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_addr;
   logic                  halt_req;
   logic                  halted;
   logic [ADDR_WIDTH-1:0] pc_out;
   logic [CNT_WIDTH-1:0]  issue_count;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output inst_valid, inst_out, inst_pc,
      input  inst_ready,
      input  redirect_valid, redirect_addr, halt_req,
      output halted, pc_out, issue_count
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  inst_valid, inst_out, inst_pc,
      output inst_ready,
      output redirect_valid, redirect_addr, halt_req,
      input  halted, pc_out, issue_count
   );
endinterface

// File: rtl/pc_fetch_sequencer_pc_next_sel.sv
// pc_next_sel
//   Combinational next-PC select for the fetch sequencer.
//   Inputs : state, pc, redirect_valid/redirect_addr, inst_ready
//   Outputs: pc_next (hold / pc+PC_INCR / redirect_addr),
//            accept (decode took the instruction and it was not squashed)
//   A redirect overrides every other update in every state.
module pc_next_sel
   import pc_fetch_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned PC_INCR    = DEF_PC_INCR
) (
   input  state_t                state,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   input  logic                  inst_ready,
   output logic [ADDR_WIDTH-1:0] pc_next,
   output logic                  accept
);

   always_comb begin
      accept  = (state == S_ISSUE) && inst_ready && !redirect_valid;
      pc_next = pc;
      if (redirect_valid) begin
         pc_next = redirect_addr;
      end else if (accept) begin
         // Wraps modulo 2^ADDR_WIDTH by construction.
         pc_next = pc + ADDR_WIDTH'(PC_INCR);
      end
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Holds the architectural PC, issues one instruction-memory fetch at a
//   time and presents the fetched word to decode over valid/ready.
//   Execute redirects, halt/resume and an issued-instruction counter are
//   handled here.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - pc_fetch_sequencer_if.master (imem, decode, redirect, status)
module pc_fetch_sequencer
   import pc_fetch_sequencer_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned           INST_WIDTH = DEF_INST_WIDTH,
   parameter int unsigned           PC_INCR    = DEF_PC_INCR,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
   parameter int unsigned           CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   pc_fetch_sequencer_if.master  bus
);

   state_t                state;
   state_t                state_nx;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic                  accept;
   logic                  pending;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_live;
   logic [INST_WIDTH-1:0] inst_q;
   logic [ADDR_WIDTH-1:0] inst_pc_q;
   logic [CNT_WIDTH-1:0]  cnt;
   logic                  fetch_ack;

   // req_live holds the request low from reset until the first clock
   // edge after rst deasserts, so imem_req stays a pure register decode.
   assign fetch_ack = (state == S_FETCH) && req_live && bus.imem_ack;

   pc_next_sel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .PC_INCR    (PC_INCR)
   ) u_pc_next_sel (
      .state          (state),
      .pc             (pc),
      .redirect_valid (bus.redirect_valid),
      .redirect_addr  (bus.redirect_addr),
      .inst_ready     (bus.inst_ready),
      .pc_next        (pc_next),
      .accept         (accept)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH: begin
            if (fetch_ack && !pending && !bus.redirect_valid) begin
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.redirect_valid) begin
               state_nx = S_FETCH;
            end else if (bus.inst_ready) begin
               state_nx = bus.halt_req ? S_HALT : S_FETCH;
            end
         end
         S_HALT: begin
            if (bus.redirect_valid) begin
               state_nx = S_FETCH;
            end
         end
         default: state_nx = S_FETCH;
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      bus.imem_req   = 1'b0;
      bus.inst_valid = 1'b0;
      bus.halted     = 1'b0;
      case (state)
         S_FETCH: bus.imem_req   = req_live;
         S_ISSUE: bus.inst_valid = 1'b1;
         S_HALT:  bus.halted     = 1'b1;
         default: ;
      endcase
   end

   // While a redirected fetch is still outstanding, pc already holds the
   // target; the request address stays on the original until the ack.
   assign bus.imem_addr   = pending ? req_addr : pc;
   assign bus.inst_out    = inst_q;
   assign bus.inst_pc     = inst_pc_q;
   assign bus.pc_out      = pc;
   assign bus.issue_count = cnt;

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc        <= RESET_ADDR;
         pending   <= 1'b0;
         req_addr  <= '0;
         req_live  <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
         cnt       <= '0;
      end else begin
         req_live <= 1'b1;
         pc       <= pc_next;
         if ((state == S_FETCH) && req_live) begin
            if (bus.imem_ack) begin
               pending <= 1'b0;
               if (!pending && !bus.redirect_valid) begin
                  inst_q    <= bus.imem_rdata;
                  inst_pc_q <= pc;
               end
            end else if (bus.redirect_valid) begin
               pending <= 1'b1;
               // Only the first redirect captures the in-flight address.
               if (!pending) begin
                  req_addr <= pc;
               end
            end
         end
         if (accept) begin
            cnt <= cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule
